// File: rtl/lcd_char_ctrl.sv
// HD44780-compatible 8-bit write-only character LCD controller.
// Runs the power-up init sequence, then turns accepted characters into bus writes while tracking the cursor.
module lcd_char_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int COLS       = 16,
    parameter int ROWS       = 2,
    parameter int POWERUP_US = 20000,
    parameter int CMD_US     = 50,
    parameter int CLR_US     = 2000,
    parameter int E_CYCLES   = 16,
    parameter int DESC_MAP   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_Data_Valid,
    input  logic [7:0] i_Data_Character,
    output logic       o_Display_Ready,
    output logic [7:0] o_LCD,
    output logic       o_LCD_RS,
    output logic       o_LCD_RW,
    output logic       o_LCD_E,
    output logic [1:0] o_Cursor_Row,
    output logic [5:0] o_Cursor_Col,
    output logic [2:0] o_Debug_State
);

    localparam int TUS     = (CLK_HZ / 1000000 < 1) ? 1 : CLK_HZ / 1000000;
    localparam int PWR_CYC = POWERUP_US * TUS;
    localparam int CMD_CYC = CMD_US * TUS;
    localparam int CLR_CYC = CLR_US * TUS;
    localparam int MAX_A   = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
    localparam int MAX_B   = (CMD_CYC > E_CYCLES) ? CMD_CYC : E_CYCLES;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [7:0] FUNC_SET = (ROWS == 1) ? 8'h30 : 8'h38;

    typedef enum logic [2:0] {
        S_INIT_WAIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    // Pending writes of the current operation: bit 8 is RS, bits 7:0 the bus byte.
    logic [8:0]    wq [0:4];
    logic [2:0]    wq_len;
    logic [2:0]    wq_idx;
    logic [2:0]    idx_nx;
    logic [2:0]    last_idx;
    logic          clr_pend;
    logic [1:0]    nxt_row;
    logic [5:0]    nxt_col;
    logic          nxt_pend;
    logic [TW-1:0] exec_lim;

    logic [8:0]    plan_q [0:2];
    logic [2:0]    plan_len;
    logic [1:0]    plan_row;
    logic [5:0]    plan_col;
    logic          plan_pend;

    assign o_LCD_RW      = 1'b0;
    assign o_Debug_State = state;
    assign idx_nx        = wq_idx + 3'd1;
    assign last_idx      = wq_len - 3'd1;
    assign exec_lim      = (wq[wq_idx] == 9'h001) ? TW'(CLR_CYC - 1) : TW'(CMD_CYC - 1);

    function automatic logic [7:0] row_addr(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h80;
            2'd1:    return 8'hC0;
            2'd2:    return 8'h80 | 8'(COLS);
            default: return 8'h80 | 8'(8'h40 + COLS);
        endcase
    endfunction

    function automatic logic [1:0] row_inc(input logic [1:0] r);
        return (int'(r) + 1 >= ROWS) ? 2'd0 : r + 2'd1;
    endfunction

    function automatic logic [7:0] remap(input logic [7:0] c);
        if (DESC_MAP == 0) return c;
        case (c)
            8'h67:   return 8'hE7;
            8'h70:   return 8'hF0;
            8'h71:   return 8'hF1;
            8'h79:   return 8'hF9;
            default: return c;
        endcase
    endfunction

    // Decode the offered character into its write list and the cursor it leaves behind.
    always_comb begin
        plan_q[0] = '0;
        plan_q[1] = '0;
        plan_q[2] = '0;
        plan_len  = 3'd1;
        plan_row  = o_Cursor_Row;
        plan_col  = o_Cursor_Col;
        plan_pend = clr_pend;
        case (i_Data_Character)
            8'h0D: begin
                plan_q[0] = {1'b0, row_addr(o_Cursor_Row)};
                plan_col  = '0;
            end
            8'h0A: begin
                plan_row  = row_inc(o_Cursor_Row);
                plan_q[0] = {1'b0, row_addr(plan_row)};
                plan_col  = '0;
            end
            8'h0C: begin
                plan_q[0] = 9'h001;
                plan_row  = '0;
                plan_col  = '0;
                plan_pend = 1'b0;
            end
            default: begin
                if (clr_pend) begin
                    plan_q[0] = 9'h001;
                    plan_q[1] = {1'b0, row_addr(o_Cursor_Row)};
                    plan_q[2] = {1'b1, remap(i_Data_Character)};
                    plan_len  = 3'd3;
                    plan_pend = 1'b0;
                end else if (o_Cursor_Col == '0) begin
                    plan_q[0] = {1'b0, row_addr(o_Cursor_Row)};
                    plan_q[1] = {1'b1, remap(i_Data_Character)};
                    plan_len  = 3'd2;
                end else begin
                    plan_q[0] = {1'b1, remap(i_Data_Character)};
                end
                if (int'(o_Cursor_Col) + 1 >= COLS) begin
                    plan_col = '0;
                    if (int'(o_Cursor_Row) + 1 >= ROWS) begin
                        plan_row  = '0;
                        plan_pend = 1'b1;
                    end else begin
                        plan_row = o_Cursor_Row + 2'd1;
                    end
                end else begin
                    plan_col = o_Cursor_Col + 6'd1;
                end
            end
        endcase
    end

    // Handshake: a character transfers on any clock edge where i_Data_Valid and
    // o_Display_Ready are both high; ready is high only in IDLE, so at most one
    // character is in flight and a held valid waits without being consumed.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_INIT_WAIT;
            timer           <= '0;
            o_Display_Ready <= 1'b0;
            o_LCD           <= '0;
            o_LCD_RS        <= 1'b0;
            o_LCD_E         <= 1'b0;
            o_Cursor_Row    <= '0;
            o_Cursor_Col    <= '0;
            clr_pend        <= 1'b0;
            nxt_row         <= '0;
            nxt_col         <= '0;
            nxt_pend        <= 1'b0;
            wq_len          <= '0;
            wq_idx          <= '0;
            for (int i = 0; i < 5; i++) wq[i] <= '0;
        end else begin
            case (state)
                S_INIT_WAIT: begin
                    if (timer == TW'(PWR_CYC - 1)) begin
                        wq[0]    <= {1'b0, FUNC_SET};
                        wq[1]    <= {1'b0, FUNC_SET};
                        wq[2]    <= 9'h00C;
                        wq[3]    <= 9'h001;
                        wq[4]    <= 9'h006;
                        wq_len   <= 3'd5;
                        wq_idx   <= '0;
                        nxt_row  <= '0;
                        nxt_col  <= '0;
                        nxt_pend <= 1'b0;
                        o_LCD    <= FUNC_SET;
                        o_LCD_RS <= 1'b0;
                        state    <= S_SETUP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_IDLE: begin
                    if (i_Data_Valid) begin
                        for (int i = 0; i < 3; i++) wq[i] <= plan_q[i];
                        wq_len          <= plan_len;
                        wq_idx          <= '0;
                        nxt_row         <= plan_row;
                        nxt_col         <= plan_col;
                        nxt_pend        <= plan_pend;
                        o_Display_Ready <= 1'b0;
                        o_LCD           <= plan_q[0][7:0];
                        o_LCD_RS        <= plan_q[0][8];
                        if (plan_len == 3'd1) begin
                            o_Cursor_Row <= plan_row;
                            o_Cursor_Col <= plan_col;
                            clr_pend     <= plan_pend;
                        end
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    o_LCD_E <= 1'b1;
                    timer   <= '0;
                    state   <= S_PULSE;
                end
                S_PULSE: begin
                    if (timer == TW'(E_CYCLES - 1)) begin
                        o_LCD_E <= 1'b0;
                        state   <= S_HOLD;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_HOLD: begin
                    o_LCD    <= '0;
                    o_LCD_RS <= 1'b0;
                    timer    <= '0;
                    state    <= S_EXEC;
                end
                S_EXEC: begin
                    if (timer == exec_lim) begin
                        if (wq_idx == last_idx) begin
                            o_Display_Ready <= 1'b1;
                            state           <= S_IDLE;
                        end else begin
                            // Next write follows immediately; the last one publishes the cursor.
                            wq_idx   <= idx_nx;
                            o_LCD    <= wq[idx_nx][7:0];
                            o_LCD_RS <= wq[idx_nx][8];
                            if (idx_nx == last_idx) begin
                                o_Cursor_Row <= nxt_row;
                                o_Cursor_Col <= nxt_col;
                                clr_pend     <= nxt_pend;
                            end
                            state <= S_SETUP;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= S_INIT_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Bench for lcd_char_ctrl: a bus monitor scores every E pulse against writes predicted
// by a cursor-position model; scenario tasks check timing, cursor and reset behaviour.
module tb_lcd_char_ctrl;

    localparam int CLK_HZ     = 1000000;
    localparam int COLS       = 4;
    localparam int ROWS       = 2;
    localparam int POWERUP_US = 100;
    localparam int CMD_US     = 5;
    localparam int CLR_US     = 20;
    localparam int E_CYCLES   = 2;
    localparam int DESC_MAP   = 1;
    localparam int OP         = 2 + E_CYCLES;
    localparam int CMD_CYC    = CMD_US;
    localparam int CLR_CYC    = CLR_US;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       i_Data_Valid = 1'b0;
    logic [7:0] i_Data_Character = 8'h00;
    logic       o_Display_Ready;
    logic [7:0] o_LCD;
    logic       o_LCD_RS;
    logic       o_LCD_RW;
    logic       o_LCD_E;
    logic [1:0] o_Cursor_Row;
    logic [5:0] o_Cursor_Col;
    logic [2:0] o_Debug_State;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [8:0] exp_q[$];
    int         rise_q[$];
    int         m_row = 0;
    int         m_col = 0;
    bit         m_pend = 1'b0;

    lcd_char_ctrl #(
        .CLK_HZ(CLK_HZ), .COLS(COLS), .ROWS(ROWS), .POWERUP_US(POWERUP_US),
        .CMD_US(CMD_US), .CLR_US(CLR_US), .E_CYCLES(E_CYCLES), .DESC_MAP(DESC_MAP)
    ) dut (
        .clock(clock), .reset(reset),
        .i_Data_Valid(i_Data_Valid), .i_Data_Character(i_Data_Character),
        .o_Display_Ready(o_Display_Ready), .o_LCD(o_LCD), .o_LCD_RS(o_LCD_RS),
        .o_LCD_RW(o_LCD_RW), .o_LCD_E(o_LCD_E), .o_Cursor_Row(o_Cursor_Row),
        .o_Cursor_Col(o_Cursor_Col), .o_Debug_State(o_Debug_State)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // bus monitor + scoreboard
    bit         in_pulse = 1'b0;
    bit         p_stable;
    int         p_w;
    logic [8:0] p_word;
    logic [8:0] prev_bus = '0;
    always @(negedge clock) begin
        logic [8:0] e;
        if (reset) begin
            in_pulse = 1'b0;
        end else if (o_LCD_E === 1'b1) begin
            if (!in_pulse) begin
                in_pulse = 1'b1;
                p_word   = {o_LCD_RS, o_LCD};
                p_w      = 1;
                p_stable = (prev_bus === p_word);
                rise_q.push_back(cyc);
            end else begin
                p_w++;
                if ({o_LCD_RS, o_LCD} !== p_word) p_stable = 1'b0;
            end
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            if ({o_LCD_RS, o_LCD} !== p_word) p_stable = 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got rs/data %h, expected none", p_word);
            end else begin
                e = exp_q.pop_front();
                if (p_word !== e) begin
                    errors++;
                    $display("FAIL write_word: got rs/data %h, expected %h", p_word, e);
                end
            end
            checks++;
            if (p_w != E_CYCLES) begin
                errors++;
                $display("FAIL pulse_width: got %0d cycles, expected %0d", p_w, E_CYCLES);
            end
            checks++;
            if (!p_stable) begin
                errors++;
                $display("FAIL bus_setup_hold: rs/data %h not held through setup/pulse/hold", p_word);
            end
        end
        prev_bus = {o_LCD_RS, o_LCD};
    end

    // reference model: cursor as a linear screen position
    function automatic logic [7:0] remap(input logic [7:0] c);
        case (c)
            8'h67:   return 8'hE7;
            8'h70:   return 8'hF0;
            8'h71:   return 8'hF1;
            8'h79:   return 8'hF9;
            default: return c;
        endcase
    endfunction

    function automatic logic [7:0] addr_cmd(input int r);
        return 8'(128 + (r % 2) * 64 + (r / 2) * COLS);
    endfunction

    task automatic model_char(input logic [7:0] c, output int busy);
        int pos;
        busy = 0;
        if (c == 8'h0D) begin
            m_col = 0;
            exp_q.push_back({1'b0, addr_cmd(m_row)});
            busy = OP + CMD_CYC;
        end else if (c == 8'h0A) begin
            m_row = (m_row + 1) % ROWS;
            m_col = 0;
            exp_q.push_back({1'b0, addr_cmd(m_row)});
            busy = OP + CMD_CYC;
        end else if (c == 8'h0C) begin
            m_row = 0; m_col = 0; m_pend = 1'b0;
            exp_q.push_back(9'h001);
            busy = OP + CLR_CYC;
        end else begin
            if (m_pend) begin
                exp_q.push_back(9'h001);
                exp_q.push_back({1'b0, addr_cmd(m_row)});
                busy += 2 * OP + CLR_CYC + CMD_CYC;
                m_pend = 1'b0;
            end else if (m_col == 0) begin
                exp_q.push_back({1'b0, addr_cmd(m_row)});
                busy += OP + CMD_CYC;
            end
            exp_q.push_back({1'b1, remap(c)});
            busy += OP + CMD_CYC;
            pos = m_row * COLS + m_col + 1;
            if (pos == ROWS * COLS) begin
                pos = 0;
                m_pend = 1'b1;
            end
            m_row = pos / COLS;
            m_col = pos % COLS;
        end
    endtask

    // driver: offer one character, scramble the data after accept, count ready-low cycles
    task automatic send_char(input logic [7:0] c, output int low);
        int n = 0;
        while (o_Display_Ready !== 1'b1 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (o_Display_Ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: ready=%b before sending %h, expected 1", o_Display_Ready, c);
        end
        i_Data_Valid     = 1'b1;
        i_Data_Character = c;
        @(negedge clock);
        i_Data_Valid     = 1'b0;
        i_Data_Character = 8'($urandom);
        low = 0;
        while (o_Display_Ready !== 1'b1 && low < 1000) begin
            low++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        int rel, bad, n, rdy_cyc;
        reset        = 1'b1;
        i_Data_Valid = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({o_LCD_E, o_LCD_RS, o_LCD_RW, o_Display_Ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got E/RS/RW/ready %b%b%b%b, expected 0000",
                     o_LCD_E, o_LCD_RS, o_LCD_RW, o_Display_Ready);
        end
        checks++;
        if (o_LCD !== 8'h00 || o_Cursor_Row !== 2'd0 || o_Cursor_Col !== 6'd0) begin
            errors++;
            $display("FAIL reset_bus_cursor: got lcd=%h row=%0d col=%0d, expected 00/0/0",
                     o_LCD, o_Cursor_Row, o_Cursor_Col);
        end
        exp_q.delete();
        rise_q.delete();
        m_row = 0; m_col = 0; m_pend = 1'b0;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(9'h038); exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001); exp_q.push_back(9'h006);
        rel   = cyc;
        reset = 1'b0;
        bad   = 0;
        for (int i = 0; i < POWERUP_US; i++) begin
            @(negedge clock);
            if (o_Display_Ready !== 1'b0 || o_LCD_E !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL powerup_quiet: %0d active cycles in power-up wait, expected 0", bad);
        end
        n = 0;
        while (o_Display_Ready !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        rdy_cyc = cyc;
        checks++;
        if (o_Display_Ready !== 1'b1 || exp_q.size() != 0 || rise_q.size() != 5) begin
            errors++;
            $display("FAIL init_complete: ready=%b pending=%0d pulses=%0d, expected 1/0/5",
                     o_Display_Ready, exp_q.size(), rise_q.size());
        end
        if (rise_q.size() == 5) begin
            checks++;
            if (rise_q[0] - rel != POWERUP_US + 1) begin
                errors++;
                $display("FAIL first_cmd_time: got %0d cycles, expected %0d", rise_q[0] - rel, POWERUP_US + 1);
            end
            checks++;
            if (rise_q[3] - rise_q[2] != OP + CMD_CYC) begin
                errors++;
                $display("FAIL cmd_spacing: got %0d, expected %0d", rise_q[3] - rise_q[2], OP + CMD_CYC);
            end
            checks++;
            if (rise_q[4] - rise_q[3] != OP + CLR_CYC) begin
                errors++;
                $display("FAIL clear_spacing: got %0d, expected %0d", rise_q[4] - rise_q[3], OP + CLR_CYC);
            end
            checks++;
            if (rdy_cyc - rise_q[4] != E_CYCLES + 1 + CMD_CYC) begin
                errors++;
                $display("FAIL init_ready_time: got %0d, expected %0d", rdy_cyc - rise_q[4], E_CYCLES + 1 + CMD_CYC);
            end
        end
    endtask

    task automatic test_single_char();
        int busy, low;
        model_char(8'h41, busy);
        send_char(8'h41, low);
        checks++;
        if (low != busy || busy != 18) begin
            errors++;
            $display("FAIL char_A_busy: got %0d ready-low cycles, expected 18", low);
        end
        checks++;
        if (o_Cursor_Row !== 2'd0 || o_Cursor_Col !== 6'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL char_A_cursor: got (%0d,%0d) pending=%0d, expected (0,1) pending=0",
                     o_Cursor_Row, o_Cursor_Col, exp_q.size());
        end
    endtask

    task automatic test_row_wrap();
        int busy, low;
        logic [7:0] s1 [3] = '{8'h62, 8'h63, 8'h64};
        logic [7:0] s2 [3] = '{8'h66, 8'h67, 8'h68};
        foreach (s1[i]) begin model_char(s1[i], busy); send_char(s1[i], low); end
        checks++;
        if (o_Cursor_Row !== 2'd1 || o_Cursor_Col !== 6'd0) begin
            errors++;
            $display("FAIL wrap_row1: got (%0d,%0d), expected (1,0)", o_Cursor_Row, o_Cursor_Col);
        end
        model_char(8'h65, busy);
        send_char(8'h65, low);
        checks++;
        if (low != busy || o_Cursor_Row !== 2'd1 || o_Cursor_Col !== 6'd1) begin
            errors++;
            $display("FAIL char_e: got busy=%0d (%0d,%0d), expected busy=%0d (1,1)",
                     low, o_Cursor_Row, o_Cursor_Col, busy);
        end
        foreach (s2[i]) begin model_char(s2[i], busy); send_char(s2[i], low); end
        checks++;
        if (o_Cursor_Row !== 2'd0 || o_Cursor_Col !== 6'd0) begin
            errors++;
            $display("FAIL wrap_screen: got (%0d,%0d), expected (0,0)", o_Cursor_Row, o_Cursor_Col);
        end
        rise_q.delete();
        model_char(8'h70, busy);
        send_char(8'h70, low);
        checks++;
        if (low != 42 || busy != 42) begin
            errors++;
            $display("FAIL char_p_busy: got %0d, expected 42", low);
        end
        checks++;
        if (rise_q.size() != 3 || o_Cursor_Row !== 2'd0 || o_Cursor_Col !== 6'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL char_p_result: got pulses=%0d (%0d,%0d), expected 3 (0,1)",
                     rise_q.size(), o_Cursor_Row, o_Cursor_Col);
        end else begin
            checks++;
            if (rise_q[1] - rise_q[0] != OP + CLR_CYC) begin
                errors++;
                $display("FAIL char_p_clear_wait: got %0d, expected %0d", rise_q[1] - rise_q[0], OP + CLR_CYC);
            end
        end
    endtask

    task automatic test_cr_ff();
        int busy, low;
        logic [7:0] s [5] = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
        foreach (s[i]) begin model_char(s[i], busy); send_char(s[i], low); end
        model_char(8'h0D, busy);
        send_char(8'h0D, low);
        checks++;
        if (low != OP + CMD_CYC || o_Cursor_Row !== 2'd1 || o_Cursor_Col !== 6'd0) begin
            errors++;
            $display("FAIL cr: got busy=%0d (%0d,%0d), expected %0d (1,0)",
                     low, o_Cursor_Row, o_Cursor_Col, OP + CMD_CYC);
        end
        model_char(8'h0C, busy);
        send_char(8'h0C, low);
        checks++;
        if (low != OP + CLR_CYC || o_Cursor_Row !== 2'd0 || o_Cursor_Col !== 6'd0) begin
            errors++;
            $display("FAIL ff: got busy=%0d (%0d,%0d), expected %0d (0,0)",
                     low, o_Cursor_Row, o_Cursor_Col, OP + CLR_CYC);
        end
        model_char(8'h0A, busy);
        send_char(8'h0A, low);
        checks++;
        if (low != busy || o_Cursor_Row !== 2'd1 || o_Cursor_Col !== 6'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL lf: got busy=%0d (%0d,%0d), expected %0d (1,0)",
                     low, o_Cursor_Row, o_Cursor_Col, busy);
        end
    endtask

    task automatic test_back_to_back();
        int busy, n;
        model_char(8'h79, busy);
        model_char(8'h4B, busy);
        n = 0;
        while (o_Display_Ready !== 1'b1 && n < 1000) begin @(negedge clock); n++; end
        i_Data_Valid     = 1'b1;
        i_Data_Character = 8'h79;
        @(negedge clock);
        i_Data_Character = 8'h4B;
        n = 0;
        while (o_Display_Ready !== 1'b1 && n < 1000) begin @(negedge clock); n++; end
        @(negedge clock);
        i_Data_Valid = 1'b0;
        n = 0;
        while (o_Display_Ready !== 1'b1 && n < 1000) begin @(negedge clock); n++; end
        repeat (3) @(negedge clock);
        checks++;
        if (exp_q.size() != 0 || o_Cursor_Row !== 2'(m_row) || o_Cursor_Col !== 6'(m_col)) begin
            errors++;
            $display("FAIL back_to_back: got pending=%0d (%0d,%0d), expected 0 (%0d,%0d)",
                     exp_q.size(), o_Cursor_Row, o_Cursor_Col, m_row, m_col);
        end
    endtask

    task automatic test_random();
        int busy, low, r, bad;
        logic [7:0] c;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 11);
            if (r == 0) c = 8'h0D;
            else if (r == 1) c = 8'h0A;
            else if (r == 2) c = 8'h0C;
            else if (r == 3) c = (i % 2 == 0) ? 8'h67 : 8'h71;
            else c = 8'($urandom_range(8'h20, 8'h7E));
            if (c == 8'h0D || c == 8'h0A || c == 8'h0C) c = (r < 3) ? c : 8'h41;
            model_char(c, busy);
            send_char(c, low);
            if (low != busy || o_Cursor_Row !== 2'(m_row) || o_Cursor_Col !== 6'(m_col)) begin
                bad++;
                $display("FAIL random_char: char %h busy=%0d (%0d,%0d), expected %0d (%0d,%0d)",
                         c, low, o_Cursor_Row, o_Cursor_Col, busy, m_row, m_col);
            end
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        checks++;
        if (bad != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_summary: %0d bad chars, %0d writes missing, expected 0/0", bad, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_pulse();
        int n = 0;
        while (o_Display_Ready !== 1'b1 && n < 1000) begin @(negedge clock); n++; end
        i_Data_Valid     = 1'b1;
        i_Data_Character = 8'h78;
        @(negedge clock);
        i_Data_Valid = 1'b0;
        n = 0;
        while (!(o_LCD_E === 1'b1 && o_LCD_RS === 1'b1) && n < 200) begin @(negedge clock); n++; end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL data_pulse_seen: no RS=1 pulse within %0d cycles", n);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (o_LCD_E !== 1'b0 || o_Display_Ready !== 1'b0 || o_LCD !== 8'h00 || o_LCD_RS !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pulse: got E=%b ready=%b lcd=%h rs=%b, expected 0/0/00/0",
                     o_LCD_E, o_Display_Ready, o_LCD, o_LCD_RS);
        end
        checks++;
        if (o_Cursor_Row !== 2'd0 || o_Cursor_Col !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid_cursor: got (%0d,%0d), expected (0,0)", o_Cursor_Row, o_Cursor_Col);
        end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_row_wrap();
        test_cr_ff();
        test_back_to_back();
        test_random();
        test_reset_mid_pulse();
        test_reset();
        test_single_char();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
